// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle between the execute stage and mul_div_unit.
//   start/kill/op/src1/src2 : request side, driven by the master (execute stage)
//   busy/done/result        : response side, driven by the slave (mul_div_unit)
interface mul_div_if #(parameter int XLEN = 32);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, kill, op, src1, src2, input busy, done, result);
    modport slave  (input start, kill, op, src1, src2, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one radix-2 step per cycle, 32 steps per op.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mul_div_if slave (start/kill/op/src1/src2 in, busy/done/result out)
module mul_div_unit #(parameter int XLEN = 32) (
    input logic      clk,
    input logic      rst,
    mul_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg1;
    logic              r_negp;
    logic              r_dz;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic              w_s1sgn;
    logic              w_s2sgn;
    logic              w_n1;
    logic              w_n2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;
    // Both datapaths run on magnitudes; signs are re-applied once at the end.
    // r_acc holds {hi, lo}: multiply keeps partial product / multiplier,
    // divide keeps partial remainder / dividend-then-quotient.
    always_comb begin
        w_s1sgn = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        w_s2sgn = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
        w_n1    = w_s1sgn & bus.src1[XLEN-1];
        w_n2    = w_s2sgn & bus.src2[XLEN-1];
        w_mag1  = w_n1 ? -bus.src1 : bus.src1;
        w_mag2  = w_n2 ? -bus.src2 : bus.src2;
        w_msum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_rsh   = r_acc[2*XLEN-1:XLEN-1];
        w_diff  = w_rsh - {1'b0, r_b};
        w_ge    = ~w_diff[XLEN];
        w_step  = r_op[2] ? {w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0], r_acc[XLEN-2:0], w_ge}
                          : {w_msum, r_acc[XLEN-1:1]};
        w_prod  = r_negp ? -w_step : w_step;
        // Divide by zero must give all ones regardless of dividend sign;
        // the remainder path already yields src1 naturally.
        w_quo   = r_dz ? {XLEN{1'b1}} : (r_negp ? -w_step[XLEN-1:0] : w_step[XLEN-1:0]);
        w_rem   = r_neg1 ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
        w_final = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                          : (r_op[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg1   <= 1'b0;
            r_negp   <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start && !bus.kill) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_op    <= bus.op;
                        r_b     <= bus.op[2] ? w_mag2 : w_mag1;
                        r_acc   <= {{XLEN{1'b0}}, bus.op[2] ? w_mag1 : w_mag2};
                        r_neg1  <= w_n1;
                        r_negp  <= w_n1 ^ w_n2;
                        r_dz    <= (bus.src2 == '0);
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_final;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed RV32M vectors.
module tb_mul_div_unit;
    typedef struct {
        logic [31:0] res;
        int          t0;
        string       name;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nb;
    logic [31:0] last = '0;
    logic        prev_done = 1'b0;
    exp_t        sb[$];
    mul_div_if bus();
    mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.done) begin
            chk("done_single_pulse", 32'(prev_done), 32'd0);
            chk("busy_low_in_done", 32'(bus.busy), 32'd0);
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, bus.result, e.res);
                chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'd32);
            end
        end
        prev_done = bus.done;
    end
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input string nm, input bit push);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src1  = a;
        bus.src2  = b;
        if (push) begin
            sb.push_back('{res: r, t0: cyc + 1, name: nm});
            last = r;
        end
    endtask
    task automatic wait_done(output int busy_cnt);
        int n = 0;
        busy_cnt = 0;
        while (!bus.done && n < 80) begin
            busy_cnt += int'(bus.busy);
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(bus.done), 32'd1);
    endtask
    task automatic fire(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input string nm);
        int c;
        launch(o, a, b, r, nm, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.src1  = ~a;
        bus.src2  = ~b;
        wait_done(c);
        chk({nm, "_busy_cycles"}, 32'(c), 32'd32);
    endtask
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input string nm);
        @(negedge clk);
        fire(o, a, b, r, nm);
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.op = '0;
        bus.src1 = '0;
        bus.src2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        fire(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_neg");
        do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        do_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
        do_op(3'd0, 32'h12345678, 32'h10, 32'h23456780, "mul_shift");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
        do_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_by_zero");
        do_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by_zero");
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
        do_op(3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_neg_by_zero");
        do_op(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_neg_by_zero");
        // kill during the 10th CALC cycle
        @(negedge clk);
        launch(3'd5, 32'd100, 32'd7, 32'd14, "killed", 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_done", 32'(bus.done), 32'd0);
        chk("kill_result_held", bus.result, last);
        repeat (40) @(negedge clk);
        // kill together with start in IDLE: request refused
        bus.kill = 1'b1;
        launch(3'd0, 32'd3, 32'd3, 32'd9, "kill_start", 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill = 1'b0;
        chk("kill_start_busy", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        // start while in CALC must be ignored
        launch(3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, "rem_pos_neg", 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        launch(3'd0, 32'd3, 32'd3, 32'd9, "ignored", 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(nb);
        repeat (40) @(negedge clk);
        // start held during DONE: back-to-back issue
        fire(3'd5, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, "b2b_a");
        launch(3'd3, 32'h10000, 32'h10000, 32'd1, "b2b_b", 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(nb);
        chk("b2b_b_busy_cycles", 32'(nb), 32'd32);
        // asynchronous reset mid-CALC
        @(negedge clk);
        launch(3'd0, 32'd5, 32'd5, 32'd25, "abandoned", 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        chk("async_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
